// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
// Holds the lock-state encoding and the requester index constants.
// No logic; imported by the arbiter top and its round-robin picker.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } lock_state_e;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant picker with per-requester mask.
// Latency: purely combinational, grant in the request cycle.
// Backpressure: a masked or losing requester simply sees no grant and holds.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_0,
  input  logic       req_1,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic       gnt_0,
  output logic       gnt_1
);

  logic w_req_0;
  logic w_req_1;

  assign w_req_0 = req_0 & ~mask[0];
  assign w_req_1 = req_1 & ~mask[1];

  // Lone eligible requester wins; on conflict the one not served last wins.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (w_req_0 && w_req_1) begin
      gnt_0 = (last_grant == REQ_1);
      gnt_1 = (last_grant == REQ_0);
    end else begin
      gnt_0 = w_req_0;
      gnt_1 = w_req_1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one data-memory port; MEM_ARB_LOCK_EN adds bus locking.
// Latency: grant combinational (N), memory strobes N+1, read response N+2.
// Backpressure: losers see gnt low and hold their request; a grant is accepted every cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             we_0,
  input  logic             we_1,
  input  logic [WIDTH-1:0] addr_0,
  input  logic [WIDTH-1:0] addr_1,
  input  logic [WIDTH-1:0] wdata_0,
  input  logic [WIDTH-1:0] wdata_1,
  input  logic             lock_0,
  input  logic             lock_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             rvalid_0,
  output logic             rvalid_1,
  output logic [WIDTH-1:0] rdata_0,
  output logic [WIDTH-1:0] rdata_1,
  output logic             Memread,
  output logic             Memwrite,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  // Only the low DEPTH_LOG2 word-address bits reach the memory.
  localparam logic [WIDTH-1:0] ADDR_MASK = ~({WIDTH{1'b1}} << DEPTH_LOG2);

  logic             w_gnt_0;
  logic             w_gnt_1;
  logic             w_gnt_any;
  logic [1:0]       w_mask;
  logic             w_we;
  logic [WIDTH-1:0] w_addr;
  logic [WIDTH-1:0] w_wdata;

  logic             r_last_grant;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_req_id;
  logic             r_rvalid_0;
  logic             r_rvalid_1;
  logic [WIDTH-1:0] r_rdata_0;
  logic [WIDTH-1:0] r_rdata_1;

  rr_arb2 u_rr_arb2 (
    .req_0      (req_0),
    .req_1      (req_1),
    .last_grant (r_last_grant),
    .mask       (w_mask),
    .gnt_0      (w_gnt_0),
    .gnt_1      (w_gnt_1)
  );

`ifdef MEM_ARB_LOCK_EN
  lock_state_e r_lock_state;
  lock_state_e w_lock_next;

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock_state <= UNLOCKED;
    else        r_lock_state <= w_lock_next;
  end

  // Locked owner masks the other side; only a grant to someone moves the lock,
  // so an owner that drops req keeps the bus reserved.
  always_comb begin
    w_lock_next = r_lock_state;
    w_mask      = 2'b00;
    case (r_lock_state)
      LOCKED_0: w_mask = 2'b10;
      LOCKED_1: w_mask = 2'b01;
      default:  w_mask = 2'b00;
    endcase
    if (w_gnt_0)      w_lock_next = lock_0 ? LOCKED_0 : UNLOCKED;
    else if (w_gnt_1) w_lock_next = lock_1 ? LOCKED_1 : UNLOCKED;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = lock_0 | lock_1;
  assign w_mask        = 2'b00;
`endif

  assign gnt_0     = w_gnt_0;
  assign gnt_1     = w_gnt_1;
  assign w_gnt_any = w_gnt_0 | w_gnt_1;
  assign w_we      = w_gnt_1 ? we_1    : we_0;
  assign w_addr    = w_gnt_1 ? addr_1  : addr_0;
  assign w_wdata   = w_gnt_1 ? wdata_1 : wdata_0;

  // Remember who was served last; reset favours requester 0 on first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_last_grant <= REQ_1;
    else if (w_gnt_any) r_last_grant <= w_gnt_1 ? REQ_1 : REQ_0;
  end

  // Register the granted command for the memory cycle; strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_req_id    <= REQ_0;
    end else begin
      r_mem_rd <= w_gnt_any & ~w_we;
      r_mem_wr <= w_gnt_any &  w_we;
      if (w_gnt_any) begin
        r_mem_addr  <= w_addr & ADDR_MASK;
        r_mem_wdata <= w_wdata;
        r_req_id    <= w_gnt_1;
      end
    end
  end

  // Capture read data at the end of the memory cycle and route it back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid_0 <= 1'b0;
      r_rvalid_1 <= 1'b0;
      r_rdata_0  <= '0;
      r_rdata_1  <= '0;
    end else begin
      r_rvalid_0 <= r_mem_rd & (r_req_id == REQ_0);
      r_rvalid_1 <= r_mem_rd & (r_req_id == REQ_1);
      if (r_mem_rd && (r_req_id == REQ_0)) r_rdata_0 <= mem_rdata;
      if (r_mem_rd && (r_req_id == REQ_1)) r_rdata_1 <= mem_rdata;
    end
  end

  assign Memread   = r_mem_rd;
  assign Memwrite  = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rvalid_0  = r_rvalid_0;
  assign rvalid_1  = r_rvalid_1;
  assign rdata_0   = r_rdata_0;
  assign rdata_1   = r_rdata_1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected grants,
// memory commands and read responses; a negedge monitor pops and compares them.
// Lock scenarios follow MEM_ARB_LOCK_EN when that macro is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, req_1, we_0, we_1, lock_0, lock_1;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1, Memread, Memwrite;
  logic [31:0] rdata_0, rdata_1, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.WIDTH(32), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .lock_0(lock_0), .lock_1(lock_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rdata_0(rdata_0), .rdata_1(rdata_1),
    .Memread(Memread), .Memwrite(Memwrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: word i initially holds i.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = i;
  always @(posedge clk) if (Memwrite) mem[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:0]];

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { int cyc; logic id; } g_t;
  typedef struct { int cyc; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; } m_t;
  typedef struct { int cyc; logic id; logic [31:0] data; } r_t;
  g_t gq[$];
  m_t mq[$];
  r_t rq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc_cnt, act, exp);
    end
  endtask

  task automatic set_idle();
    req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; lock_0 = 0; lock_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
  endtask

  // One cycle of stimulus. eg = expected granted requester (-1 none),
  // exp_rd = hand-computed read data, follow = expect strobe/response after grant.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic l0,
                      input logic r1, input logic w1, input logic [31:0] a1,
                      input logic [31:0] d1, input logic l1,
                      input int eg, input logic [31:0] exp_rd, input bit follow = 1'b1);
    int c;
    logic id, we;
    logic [31:0] a, d;
    @(posedge clk); #1;
    req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0; lock_0 = l0;
    req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1; lock_1 = l1;
    c = cyc_cnt;
    if (eg >= 0) begin
      id = (eg == 1);
      we = id ? w1 : w0;
      a  = id ? a1 : a0;
      d  = id ? d1 : d0;
      gq.push_back('{c, id});
      if (follow) begin
        mq.push_back('{c + 1, !we, we, a & 32'h0000_03FF, d});
        if (!we) rq.push_back('{c + 2, id, exp_rd});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    {gnt_0, gnt_1}, 0);
    chk({tag, "_strobe"}, {Memread, Memwrite}, 0);
    chk({tag, "_rvalid"}, {rvalid_0, rvalid_1}, 0);
    chk({tag, "_maddr"},  mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_rdata0"}, rdata_0, 0);
    chk({tag, "_rdata1"}, rdata_1, 0);
  endtask

  // Monitor: every cycle out of reset compare presence and content of outputs.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit eg, em, er;
      eg = (gq.size() > 0) && (gq[0].cyc == cyc_cnt);
      em = (mq.size() > 0) && (mq[0].cyc == cyc_cnt);
      er = (rq.size() > 0) && (rq[0].cyc == cyc_cnt);
      chk("gnt_onehot", gnt_0 & gnt_1, 0);
      chk("gnt_present", gnt_0 | gnt_1, eg);
      if (eg) begin
        if (gnt_0 | gnt_1) chk("gnt_id", gnt_1, gq[0].id);
        void'(gq.pop_front());
      end
      chk("strobe_onehot", Memread & Memwrite, 0);
      chk("strobe_present", Memread | Memwrite, em);
      if (em) begin
        if (Memread | Memwrite) begin
          chk("Memread", Memread, mq[0].rd);
          chk("Memwrite", Memwrite, mq[0].wr);
          chk("mem_addr", mem_addr, mq[0].addr);
          chk("mem_wdata", mem_wdata, mq[0].wdata);
        end
        void'(mq.pop_front());
      end
      chk("rvalid_onehot", rvalid_0 & rvalid_1, 0);
      chk("rvalid_present", rvalid_0 | rvalid_1, er);
      if (er) begin
        if (rvalid_0 | rvalid_1) begin
          chk("rsp_id", rvalid_1, rq[0].id);
          chk("rdata", rq[0].id ? rdata_1 : rdata_0, rq[0].data);
        end
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read from requester 0: grant now, strobe next, data after.
    step(1, 0, 5, 0, 0,  0, 0, 0, 0, 0,  0, 32'h5);
    idle(3);
    @(negedge clk);
    chk("rdata0_hold", rdata_0, 32'h5);

    // Single read from requester 1, leaves last_grant = 1.
    step(0, 0, 0, 0, 0,  1, 0, 7, 0, 0,  1, 32'h7);
    // Continuous conflict: alternate 0,1,0,1.
    step(1, 0, 10, 0, 0,  1, 0, 20, 0, 0,  0, 32'd10);
    step(1, 0, 10, 0, 0,  1, 0, 20, 0, 0,  1, 32'd20);
    step(1, 0, 10, 0, 0,  1, 0, 20, 0, 0,  0, 32'd10);
    step(1, 0, 10, 0, 0,  1, 0, 20, 0, 0,  1, 32'd20);

    // Write from 1 then read-after-write from 0 back-to-back.
    step(0, 0, 0, 0, 0,  1, 1, 3, 32'hDEADBEEF, 0,  1, 0);
    step(1, 0, 3, 0, 0,  0, 0, 0, 0, 0,  0, 32'hDEADBEEF);
    // Upper address bits are not driven to memory: 0x405 -> word 5.
    step(1, 0, 32'h405, 0, 0,  0, 0, 0, 0, 0,  0, 32'h5);

`ifdef MEM_ARB_LOCK_EN
    step(1, 0, 10, 0, 0,  1, 0, 8, 0, 1,  1, 32'd8);
    step(1, 0, 10, 0, 0,  1, 0, 9, 0, 0,  1, 32'd9);
    step(1, 0, 10, 0, 0,  0, 0, 0, 0, 0,  0, 32'd10);
    step(1, 0, 11, 0, 1,  0, 0, 0, 0, 0,  0, 32'd11);
    step(0, 0, 0, 0, 0,   1, 0, 12, 0, 0, -1, 0);
    step(1, 0, 13, 0, 0,  1, 0, 12, 0, 0,  0, 32'd13);
    step(0, 0, 0, 0, 0,   1, 0, 12, 0, 0,  1, 32'd12);
`else
    step(1, 0, 10, 0, 0,  1, 0, 8, 0, 1,  1, 32'd8);
    step(1, 0, 10, 0, 0,  1, 0, 9, 0, 0,  0, 32'd10);
    step(0, 0, 0, 0, 0,   1, 0, 9, 0, 0,  1, 32'd9);
    step(1, 0, 11, 0, 1,  0, 0, 0, 0, 0,  0, 32'd11);
    step(0, 0, 0, 0, 0,   1, 0, 12, 0, 0,  1, 32'd12);
    step(1, 0, 13, 0, 0,  0, 0, 0, 0, 0,  0, 32'd13);
`endif
    idle(3);

    // Reset the cycle after a read grant: nothing in flight may surface.
    step(1, 0, 5, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    // last_grant back to 1: requester 0 wins the first conflict.
    step(1, 0, 6, 0, 0,  1, 0, 7, 0, 0,  0, 32'd6);
    step(0, 0, 0, 0, 0,  1, 0, 7, 0, 0,  1, 32'd7);
    idle(4);

    chk("gq_drained", gq.size(), 0);
    chk("mq_drained", mq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, number of significant word-address bits driven to memory.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req_0 / req_1, input, 1: access request from requester 0 (pipeline load/store) and requester 1 (DMA/debug).
REQ-006 SHALL have ports we_0 / we_1, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports addr_0 / addr_1, input, WIDTH: word address.
REQ-008 SHALL have ports wdata_0 / wdata_1, input, WIDTH: write data.
REQ-009 SHALL have ports lock_0 / lock_1, input, 1: hold arbitration for this requester after the current transfer.
REQ-010 SHALL have ports gnt_0 / gnt_1, output, 1: request accepted this cycle.
REQ-011 SHALL have ports rvalid_0 / rvalid_1, output, 1: read data valid, one-cycle pulse.
REQ-012 SHALL have ports rdata_0 / rdata_1, output, WIDTH: read data.
REQ-013 SHALL have ports Memread / Memwrite, output, 1: data memory strobes.
REQ-014 SHALL have ports mem_addr / mem_wdata, output, WIDTH: data memory address (upper WIDTH-DEPTH_LOG2 bits zero) and write data.
REQ-015 SHALL have port mem_rdata, input, WIDTH: data memory combinational read data.

Function
REQ-016 gnt_x SHALL be combinational from req_x and arbiter state, at most one gnt asserted per cycle.
REQ-017 With one request asserted and no lock held by the other requester, that requester SHALL be granted in the same cycle.
REQ-018 With both requests asserted, the grant SHALL go to the requester not granted most recently (round-robin, last_grant register).
REQ-019 A requester SHALL hold req, we, addr, wdata, lock stable until its gnt; the arbiter SHALL sample them in the gnt cycle.
REQ-020 A granted command (cycle N) SHALL be registered and driven on Memread/Memwrite/mem_addr/mem_wdata in cycle N+1 only; the strobes are exactly one-hot or both 0.
REQ-021 For a read, mem_rdata SHALL be captured at the end of N+1; rvalid_x and rdata_x SHALL be valid in cycle N+2 for one cycle; writes produce no rvalid.
REQ-022 Grants SHALL be accepted every cycle; back-to-back transfers from either requester SHALL pipeline at one per cycle with responses in grant order.
REQ-023 rdata_x SHALL hold its last value when rvalid_x is 0.
REQ-024 Lock states: UNLOCKED, LOCKED_0, LOCKED_1; a grant with lock_x=1 SHALL enter LOCKED_x; a grant to x with lock_x=0 SHALL return to UNLOCKED; in LOCKED_x the other requester SHALL never be granted.
REQ-025 Dropping req_x while LOCKED_x SHALL NOT release the lock.

Reset
REQ-026 rst_n low SHALL asynchronously clear gnt-related state, Memread, Memwrite, rvalid_0, rvalid_1 to 0, mem_addr, mem_wdata, rdata_0, rdata_1 to 0, lock state to UNLOCKED, and last_grant to 1 so requester 0 wins the first conflict.
REQ-027 Transfers in flight at reset SHALL be discarded with no memory strobe or rvalid after rst_n rises.

Configuration
REQ-028 With macro MEM_ARB_LOCK_EN defined, REQ-024/025 SHALL apply.
REQ-029 Without MEM_ARB_LOCK_EN, lock_0/lock_1 SHALL remain ports but be ignored, the lock state SHALL be absent, and arbitration SHALL be pure round-robin.

Structure
REQ-030 A shared package SHALL hold the lock-state encoding (UNLOCKED=2'd0, LOCKED_0=2'd1, LOCKED_1=2'd2) and the requester index constants.
REQ-031 Round-robin grant selection SHALL be a sub-module rr_arb2 (inputs: two requests, last_grant, mask; outputs: two grants).

Verification
REQ-032 After reset, req_0=1, we_0=0, addr_0=5 -> gnt_0 in cycle 0, Memread=1 with mem_addr=5 in cycle 1, rvalid_0=1 with rdata_0=32'h5 in cycle 2.
REQ-033 req_0 and req_1 asserted continuously for 4 cycles -> grants 0,1,0,1; rvalid pulses follow in the same order, two cycles later.
REQ-034 req_1 write addr=3, wdata=32'hDEADBEEF, then req_0 read addr=3 in the next cycle -> rdata_0=32'hDEADBEEF.
REQ-035 With MEM_ARB_LOCK_EN: req_1 with lock_1=1, then req_1 with lock_1=0, req_0 asserted throughout -> gnt_0 only after the second gnt_1; without the macro, gnt_0 is asserted in the second cycle.
REQ-036 rst_n pulsed low the cycle after a read grant -> no Memread and no rvalid after release; all outputs read 0.
